// File: rtl/ublaze_heartbeat.sv
// Heartbeat/trigger pulse generator for an external watchdog.
// Emits a pulse of eff_width cycles every eff_period cycles. Optionally, a pulse
// is only emitted when software kicked during the previous period. Pulses and
// skipped periods are counted in saturating counters.
module ublaze_heartbeat #(
  parameter logic [31:0] DEF_PERIOD = 32'd500000000,
  parameter logic [15:0] DEF_WIDTH  = 16'd4
) (
  input  logic        sys_clk_i,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        UsrClear,
  input  logic        gate_by_kick,
  input  logic        sw_kick,
  input  logic [31:0] period,
  input  logic [15:0] pulse_width,
  output logic        EXT_TRIG_B,
  output logic [31:0] trig_cnt,
  output logic [31:0] miss_cnt,
  output logic        busy
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned WID_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               arm_q, arm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   eff_period_q, eff_period_d;
  logic [WID_W-1:0]   eff_width_q, eff_width_d;
  logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               kick_q, kick_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;

  logic               running_c;
  logic               boundary_c;
  logic               fire_c;
  logic               width_done_c;
  logic [WID_W-1:0]   new_width_c;
  logic [CNT_W-1:0]   min_period_c;
  logic [CNT_W-1:0]   new_period_c;

  // Boundary detection: one edge after enable is seen in IDLE, or when the period expires
  always_comb begin
    running_c    = (state_q != IDLE);
    boundary_c   = enable && (running_c ? (cnt_q >= eff_period_q) : arm_q);
    fire_c       = !gate_by_kick || kick_q;
    width_done_c = (cnt_q >= CNT_W'(eff_width_q));
    new_width_c  = (pulse_width == '0) ? WID_W'(1) : pulse_width;
    min_period_c = CNT_W'(new_width_c) + CNT_W'(2);
    new_period_c = (period < min_period_c) ? min_period_c : period;
  end

  // FSM state register
  always_ff @(posedge sys_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: disable wins, then boundary, then end of high time
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (boundary_c) state_d = fire_c ? HIGH : LOW;
      end
      HIGH: begin
        if (!enable)           state_d = IDLE;
        else if (boundary_c)   state_d = fire_c ? HIGH : LOW;
        else if (width_done_c) state_d = LOW;
      end
      LOW: begin
        if (!enable)         state_d = IDLE;
        else if (boundary_c) state_d = fire_c ? HIGH : LOW;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they register alongside it
  always_comb begin
    trig_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // Datapath next state: period counter, latched timing, kick flag, event counters
  always_comb begin
    arm_d        = (state_q == IDLE) && enable;
    cnt_d        = cnt_q;
    eff_period_d = eff_period_q;
    eff_width_d  = eff_width_q;
    kick_d       = kick_q;
    trig_cnt_d   = trig_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (boundary_c) begin
      cnt_d        = CNT_W'(1);
      eff_period_d = new_period_c;
      eff_width_d  = new_width_c;
    end else if (running_c && enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A kick in the boundary cycle counts toward the following period
    if (UsrClear)        kick_d = 1'b0;
    else if (sw_kick)    kick_d = 1'b1;
    else if (boundary_c) kick_d = 1'b0;

    if (UsrClear) begin
      trig_cnt_d = '0;
      miss_cnt_d = '0;
    end else if (boundary_c) begin
      if (fire_c) begin
        if (trig_cnt_q != '1) trig_cnt_d = trig_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge sys_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      arm_q        <= 1'b0;
      cnt_q        <= '0;
      eff_period_q <= DEF_PERIOD;
      eff_width_q  <= DEF_WIDTH;
      kick_q       <= 1'b0;
      trig_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      arm_q        <= arm_d;
      cnt_q        <= cnt_d;
      eff_period_q <= eff_period_d;
      eff_width_q  <= eff_width_d;
      kick_q       <= kick_d;
      trig_cnt_q   <= trig_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
    end
  end

  assign EXT_TRIG_B = trig_q;
  assign busy       = busy_q;
  assign trig_cnt   = trig_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_ublaze_heartbeat.sv
// Directed bench for ublaze_heartbeat: a table of held-input segments with
// expected outputs after each, plus hand sequences for saturation, async reset
// mid-pulse and a free-running cycle-by-cycle check.
module tb_ublaze_heartbeat;

  logic        sys_clk_i;
  logic        reset_n;
  logic        enable;
  logic        UsrClear;
  logic        gate_by_kick;
  logic        sw_kick;
  logic [31:0] period;
  logic [15:0] pulse_width;
  logic        EXT_TRIG_B;
  logic [31:0] trig_cnt;
  logic [31:0] miss_cnt;
  logic        busy;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    int unsigned cyc;
    logic        en;
    logic        gate;
    logic        kick;
    logic        clr;
    logic [31:0] per;
    logic [15:0] wid;
    logic        ext;
    logic        bsy;
    logic [31:0] tcnt;
    logic [31:0] mcnt;
  } vec_t;

  vec_t tbl[$];

  ublaze_heartbeat #(
    .DEF_PERIOD(32'd500000000),
    .DEF_WIDTH (16'd4)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .reset_n     (reset_n),
    .enable      (enable),
    .UsrClear    (UsrClear),
    .gate_by_kick(gate_by_kick),
    .sw_kick     (sw_kick),
    .period      (period),
    .pulse_width (pulse_width),
    .EXT_TRIG_B  (EXT_TRIG_B),
    .trig_cnt    (trig_cnt),
    .miss_cnt    (miss_cnt),
    .busy        (busy)
  );

  initial begin
    sys_clk_i = 1'b0;
    forever #5 sys_clk_i = ~sys_clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  // Assert reset asynchronously, verify outputs clear before any edge, release on a falling edge
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check({tag, "_rst_ext"},  32'(EXT_TRIG_B), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy),       32'd0);
    check({tag, "_rst_tcnt"}, trig_cnt,        32'd0);
    check({tag, "_rst_mcnt"}, miss_cnt,        32'd0);
    @(negedge sys_clk_i);
    reset_n = 1'b1;
  endtask

  task automatic add(input int unsigned cyc, input logic en, input logic gate, input logic kick,
                     input logic clr, input logic [31:0] per, input logic [15:0] wid,
                     input logic ext, input logic bsy, input logic [31:0] tcnt,
                     input logic [31:0] mcnt);
    vec_t v;
    v.cyc = cyc; v.en = en; v.gate = gate; v.kick = kick; v.clr = clr;
    v.per = per; v.wid = wid; v.ext = ext; v.bsy = bsy; v.tcnt = tcnt; v.mcnt = mcnt;
    tbl.push_back(v);
  endtask

  initial begin
    logic exp_ext;
    n_total      = 0;
    n_pass       = 0;
    reset_n      = 1'b1;
    enable       = 1'b1;
    UsrClear     = 1'b0;
    gate_by_kick = 1'b1;
    sw_kick      = 1'b0;
    period       = 32'd10;
    pulse_width  = 16'd3;

    // cyc en gate kick clr per wid | ext busy trig miss   (comment: edge index after)
    add( 1, 1, 1, 0, 0, 10, 3, 0, 0, 0, 0);  // 1: armed, still idle
    add( 1, 1, 1, 0, 0, 10, 3, 0, 1, 0, 1);  // 2: first boundary, no kick -> miss
    add(10, 1, 1, 0, 0, 10, 3, 0, 1, 0, 2);  // 12
    add(10, 1, 1, 0, 0, 10, 3, 0, 1, 0, 3);  // 22
    add( 2, 1, 1, 0, 0, 10, 3, 0, 1, 0, 3);  // 24
    add( 1, 1, 1, 1, 0, 10, 3, 0, 1, 0, 3);  // 25: single kick
    add( 6, 1, 1, 0, 0, 10, 3, 0, 1, 0, 3);  // 31
    add( 1, 1, 1, 0, 0, 10, 3, 1, 1, 1, 3);  // 32: kicked boundary fires
    add( 2, 1, 1, 0, 0, 10, 3, 1, 1, 1, 3);  // 34: third high cycle
    add( 1, 1, 1, 0, 0, 10, 3, 0, 1, 1, 3);  // 35: width done
    add( 7, 1, 1, 0, 0, 10, 3, 0, 1, 1, 4);  // 42: kick consumed -> miss
    add( 9, 1, 1, 0, 0, 10, 3, 0, 1, 1, 4);  // 51
    add( 1, 1, 1, 1, 0, 10, 3, 0, 1, 1, 5);  // 52: kick in boundary cycle, this one misses
    add(10, 1, 1, 0, 0, 10, 3, 1, 1, 2, 5);  // 62: that kick fires this boundary
    add(50, 1, 0, 0, 0, 10, 3, 1, 1, 7, 5);  // 112: ungated, 5 more pulses
    add( 9, 1, 0, 0, 0, 10, 3, 0, 1, 7, 5);  // 121
    add( 1, 1, 0, 1, 1, 10, 3, 1, 1, 0, 0);  // 122: clear + kick on boundary, pulse still out
    add( 1, 1, 0, 0, 0, 10, 3, 1, 1, 0, 0);  // 123
    add( 9, 1, 1, 0, 0, 10, 3, 0, 1, 0, 1);  // 132: clear beat the kick -> miss
    add(10, 1, 0, 0, 0,  1, 0, 1, 1, 1, 1);  // 142: old period, latch clamped W=1 P=3
    add( 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1);  // 143: one cycle high
    add( 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1);  // 144
    add( 1, 1, 0, 0, 0,  1, 0, 1, 1, 2, 1);  // 145: edges 3 apart
    add( 3, 1, 0, 0, 0,  1, 0, 1, 1, 3, 1);  // 148
    add( 2, 1, 0, 0, 0, 20, 0, 0, 1, 3, 1);  // 150: period changed mid-period
    add( 1, 1, 0, 0, 0, 20, 0, 1, 1, 4, 1);  // 151: still 3 apart
    add(19, 1, 0, 0, 0, 20, 0, 0, 1, 4, 1);  // 170
    add( 1, 1, 0, 0, 0, 20, 0, 1, 1, 5, 1);  // 171: now 20 apart
    add(20, 1, 0, 0, 0, 10, 3, 1, 1, 6, 1);  // 191
    add( 1, 1, 0, 0, 0, 10, 3, 1, 1, 6, 1);  // 192: second high cycle
    add( 1, 0, 0, 0, 0, 10, 3, 0, 0, 6, 1);  // 193: enable dropped
    add( 3, 0, 0, 0, 0, 10, 3, 0, 0, 6, 1);  // 196
    add( 1, 1, 0, 0, 0, 10, 3, 0, 0, 6, 1);  // 197: re-enabled, armed
    add( 1, 1, 0, 0, 0, 10, 3, 1, 1, 7, 1);  // 198: pulse on second edge

    #1;
    do_reset("init");

    for (int i = 0; i < tbl.size(); i++) begin
      enable       = tbl[i].en;
      gate_by_kick = tbl[i].gate;
      sw_kick      = tbl[i].kick;
      UsrClear     = tbl[i].clr;
      period       = tbl[i].per;
      pulse_width  = tbl[i].wid;
      repeat (tbl[i].cyc) step();
      check($sformatf("v%0d_ext",  i), 32'(EXT_TRIG_B), 32'(tbl[i].ext));
      check($sformatf("v%0d_busy", i), 32'(busy),       32'(tbl[i].bsy));
      check($sformatf("v%0d_tcnt", i), trig_cnt,        tbl[i].tcnt);
      check($sformatf("v%0d_mcnt", i), miss_cnt,        tbl[i].mcnt);
    end
    sw_kick  = 1'b0;
    UsrClear = 1'b0;

    // Saturation: preload trig_cnt near the top, next boundaries at edges 208 and 218
    step();                                   // 199
    force dut.trig_cnt_q = 32'hFFFF_FFFE;
    step();                                   // 200
    step();                                   // 201
    release dut.trig_cnt_q;
    check("sat_preload", trig_cnt, 32'hFFFF_FFFE);
    repeat (7) step();                        // 208
    check("sat_ext1",  32'(EXT_TRIG_B), 32'd1);
    check("sat_reach", trig_cnt, 32'hFFFF_FFFF);
    repeat (10) step();                       // 218
    check("sat_ext2",  32'(EXT_TRIG_B), 32'd1);
    check("sat_hold",  trig_cnt, 32'hFFFF_FFFF);

    // Async reset in the middle of that pulse
    #1;
    period       = 32'd10;
    pulse_width  = 16'd3;
    gate_by_kick = 1'b0;
    enable       = 1'b1;
    do_reset("midpulse");

    // Free run: first boundary on edge 2, then every 10 edges, 3 cycles high
    for (int k = 1; k <= 50; k++) begin
      step();
      exp_ext = (k >= 2) && (((k - 2) % 10) < 3);
      check($sformatf("free_ext_k%0d", k),  32'(EXT_TRIG_B), 32'(exp_ext));
      check($sformatf("free_busy_k%0d", k), 32'(busy),       32'(k >= 2));
    end
    check("free_tcnt", trig_cnt, 32'd5);
    check("free_mcnt", miss_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
